// File: rtl/main_mem_responder.sv
// Main-memory model and responder for the cache refill/write-through port.
// Fixed-latency block reads and word writes over a line-organised array, zeroed by a sweep after reset.
module main_mem_responder #(
  parameter int unsigned NUM_LINES = 256,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic             req_read,
  input  logic             req_write,
  output logic [511:0]     rsp_rdata,
  output logic             rsp_ready,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int unsigned IW = $clog2(NUM_LINES);
  localparam int unsigned LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_RD_WAIT,
    S_WR_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     line_q, line_d;
  logic [3:0]        word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              rsp_ready_q, rsp_ready_d;
  logic [511:0]      rsp_rdata_q, rsp_rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;

  logic [511:0]      mem_q [NUM_LINES];
  logic              mem_we;
  logic [IW-1:0]     mem_idx;
  logic [511:0]      mem_wline;
  logic [511:0]      merged_line;

  logic [IW-1:0]     req_line;
  logic              req_any;
  logic              unused_addr_bits;

  assign req_line         = req_addr[6+IW-1:6];
  assign req_any          = req_read | req_write;
  assign unused_addr_bits = ^{req_addr[31:6+IW], req_addr[1:0]};

  always_comb begin
    merged_line = mem_q[line_q];
    merged_line[{word_q, 5'b0} +: 32] = wdata_q;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    line_d      = line_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    rsp_ready_d = rsp_ready_q;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = err_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    mem_we      = 1'b0;
    mem_idx     = ptr_q;
    mem_wline   = '0;

    case (state_q)
      S_INIT: begin
        mem_we  = 1'b1;
        mem_idx = ptr_q;
        if (req_any) err_d = 1'b1;
        if (ptr_q == IW'(NUM_LINES - 1)) state_d = S_IDLE;
        else                             ptr_d   = ptr_q + 1'b1;
      end

      S_IDLE: begin
        if (req_read) begin
          line_d  = req_line;
          lat_d   = LW'(LATENCY - 1);
          state_d = S_RD_WAIT;
          if (req_write) err_d = 1'b1;
          // Single-cycle latency: ready and data must be set up at the sampling edge itself
          if (LATENCY == 1) begin
            rsp_ready_d = 1'b1;
            rsp_rdata_d = mem_q[req_line];
          end
        end else if (req_write) begin
          line_d  = req_line;
          word_d  = req_addr[5:2];
          wdata_d = req_wdata;
          lat_d   = LW'(LATENCY - 1);
          state_d = S_WR_WAIT;
          if (LATENCY == 1) rsp_ready_d = 1'b1;
        end
      end

      S_RD_WAIT, S_WR_WAIT: begin
        if (req_any) err_d = 1'b1;
        if (rsp_ready_q) begin
          rsp_ready_d = 1'b0;
          state_d     = S_IDLE;
          if (state_q == S_WR_WAIT) begin
            mem_we    = 1'b1;
            mem_idx   = line_q;
            mem_wline = merged_line;
            if (wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
          end else begin
            if (rd_count_q != '1) rd_count_d = rd_count_q + 1'b1;
          end
        end else begin
          lat_d = lat_q - 1'b1;
          if (lat_q == LW'(1)) begin
            rsp_ready_d = 1'b1;
            if (state_q == S_RD_WAIT) rsp_rdata_d = mem_q[line_q];
          end
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      ptr_q       <= '0;
      line_q      <= '0;
      word_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      rsp_ready_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      line_q      <= line_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // Array contents are defined by the post-reset sweep, so no reset here
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wline;
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_ready = rsp_ready_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule
